// File: rtl/fsm_seq_detect_param_if.sv
// Stream-side bundle for the serial pattern detector.
// The sampler drives en/x/clr_cnt and the detector returns the match strobe, the count and its progress.
interface fsm_seq_detect_param_if #(
  parameter int CNT_W = 8,
  parameter int SW    = 2
);
  // en qualifies x for one cycle; there is no back-pressure, so every en=1 cycle is consumed.
  logic             en;
  logic             x;
  logic             clr_cnt;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic [SW-1:0]    progress;

  modport master (
    output en, x, clr_cnt,
    input  y, match_cnt, progress
  );

  modport slave (
    input  en, x, clr_cnt,
    output y, match_cnt, progress
  );
endinterface

// File: rtl/fsm_seq_detect_param.sv
// Mealy detector for an arbitrary LEN-bit serial pattern with a KMP next-state table built at elaboration.
// It produces a same-cycle match strobe, a saturating match counter and the matched-prefix length.
module fsm_seq_detect_param #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  fsm_seq_detect_param_if.slave   bus
);
  localparam int          SW    = ($clog2(LEN) > 0) ? $clog2(LEN) : 1;
  localparam logic [31:0] PAT32 = 32'(PATTERN);

  generate
    if (LEN < 1 || LEN > 32 || CNT_W < 1) begin : g_bad_params
      $error("fsm_seq_detect_param: LEN must be 1..32 and CNT_W >= 1");
    end
  endgenerate

  // State value is the number of pattern bits currently matched.
  typedef enum logic [SW-1:0] {S_EMPTY = '0} state_t;

  // Longest proper prefix of PATTERN that is a suffix of (first s pattern bits, then b).
  function automatic int kmp_next(input int s, input int b);
    int   res;
    int   t_idx;
    logic ok;
    res = 0;
    for (int k = 1; k <= LEN - 1; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          t_idx = s + 1 - k + j;
          if (t_idx == s) begin
            if (PAT32[LEN-1-j] != b[0]) ok = 1'b0;
          end else if (PAT32[LEN-1-j] != PAT32[LEN-1-t_idx]) begin
            ok = 1'b0;
          end
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  logic [SW-1:0] w_nxt0 [LEN];
  logic [SW-1:0] w_nxt1 [LEN];

  // A full match in non-overlapping mode restarts from empty instead of the border.
  for (genvar g = 0; g < LEN; g++) begin : g_tbl
    localparam int N0 = (!OVERLAP && g == LEN - 1 && PAT32[0] == 1'b0) ? 0 : kmp_next(g, 0);
    localparam int N1 = (!OVERLAP && g == LEN - 1 && PAT32[0] == 1'b1) ? 0 : kmp_next(g, 1);
    assign w_nxt0[g] = SW'(N0);
    assign w_nxt1[g] = SW'(N1);
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_y;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y         = 1'b0;
    if (bus.en && !rst) begin
      w_y         = (r_state == SW'(LEN - 1)) && (bus.x == PAT32[0]);
      w_state_nxt = state_t'(bus.x ? w_nxt1[r_state] : w_nxt0[r_state]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt)         r_cnt <= '0;
    else if (w_y && (r_cnt != '1))  r_cnt <= r_cnt + 1'b1;
  end

  assign bus.y         = w_y;
  assign bus.match_cnt = r_cnt;
  assign bus.progress  = r_state;
endmodule
